axo_fetch: RTL
==============

# axo_fetch

Instruction fetch stage of the Axolotl³² core. It issues word reads on a single-outstanding req/ack memory port and buffers returned instructions in a small FIFO. It presents instruction/PC pairs, with a valid/ready handshake, to the decode stage (`axo_reg_decoder`, `axo_insn_validator`, `axo_branch_target`). Redirects, taken from `axo_branch_target.addr`, flush the buffer, and any in-flight stale response is discarded.

## Interface
- `RESET_VEC`, default `32'h0000_0000`: first fetch address; bits [1:0] must be 0.
- `DEPTH`, default `2`: FIFO entries, legal range 2..8.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_req`  out  1  read request, registered.
- `mem_addr`  out  30  word address (byte address [31:2]), registered.
- `mem_ack`  in  1  response for the current request; `mem_rdata`/`mem_err` are valid this cycle.
- `mem_rdata`  in  32  instruction word.
- `mem_err`  in  1  access fault on this response.
- `redirect`  in  1  control transfer; flush and refetch.
- `redirect_pc`  in  31  new PC, bits [31:1].
- `insn_valid`  out  1  FIFO head valid.
- `insn_ready`  in  1  consumer accepts head.
- `insn`  out  32  head instruction; 0 for fault entries.
- `insn_pc`  out  31  head PC [31:1].
- `insn_fault`  out  2  00 none, 01 misaligned target, 10 access fault.

## Operation
- State encodings:
  - **RUN**: idle or issuing.
  - **WAIT**: request outstanding.
  - **DISCARD**: request outstanding, its data is stale.
  - **HALT**: a fault entry has been queued; no further requests.
- Space rule:
  - A request may be outstanding only if `count + 1 <= DEPTH`, where `count` is the FIFO occupancy after the current edge.
  - The outstanding request's slot is reserved.
- Pop: on an edge with `insn_valid && insn_ready && !redirect`, the head is removed.
- Normal ack in WAIT:
  - If `mem_err`=0, push {`mem_rdata`, pc, 00}.
  - Then the fetch pc advances by 4, wrapping `3fffffff` to 0.
  - If space allows, `mem_req` stays 1 with the new `mem_addr`. Otherwise `mem_req` goes to 0 and the state returns to RUN.
- Ack with `mem_err`=1: push {0, pc, 10}, drop `mem_req`, enter HALT.
- `mem_req` is never withdrawn and `mem_addr` never changes before `mem_ack`.
- Redirect has priority over pop and over ack data:
  - FIFO flushed: `count`=0 and `insn_valid`=0 after the edge.
  - Fetch pc := `redirect_pc`.
  - If `redirect_pc[1]`=1, push {0, `redirect_pc`, 01} and enter HALT. If a request is outstanding and unacked, go to DISCARD instead, then HALT after its ack.
  - Else, if a request is outstanding and not acked this edge: go to DISCARD, holding `mem_req`/`mem_addr`.
  - Else (no outstanding request, or acked this edge): the ack data is dropped, `mem_req`=1 and `mem_addr`=`redirect_pc[31:2]` next cycle, state WAIT.
- DISCARD:
  - On ack, drop the data (including `mem_err`).
  - Then issue the request for the latest redirect target on the next cycle.
  - A redirect during DISCARD only updates the target.
- HALT: exited only by a redirect.
- Fault entries pop like normal entries.

## Timing
- Reset, asynchronous and immediate:
  - `mem_req`=0, `mem_addr`=`RESET_VEC[31:2]`.
  - `insn_valid`=0, `insn`=0, `insn_pc`=`RESET_VEC[31:1]`, `insn_fault`=0.
  - FIFO empty, state RUN.
  - Reset mid-transaction abandons the request; the memory is reset by the same `rst`.
- First cycle after reset release: `mem_req`=1 at `RESET_VEC`.
- Latency from ack edge to the entry on `insn_valid` is 1 cycle (registered FIFO).
- With zero-wait memory (ack every cycle) and the consumer always ready, throughput is 1 instruction/cycle for `DEPTH`>=2.
- Simultaneous push and pop when full-minus-one is legal; occupancy holds.
- When `insn_valid`=0, `insn`, `insn_pc` and `insn_fault` are don't-care except at reset.
- Redirect response:
  - With no request outstanding, the first new request appears 1 cycle after the redirect edge.
  - With a stale request, it appears 1 cycle after the stale ack.

## Test plan
- Reset release, memory always acks, consumer always ready:
  - Required: `mem_addr` runs 0,1,2,… on consecutive cycles.
  - Required: `insn_pc` words 0,4,8 (byte addresses) appear with one-cycle lag.
- Consumer stalled (`insn_ready`=0) with `DEPTH`=2:
  - Required: exactly 2 entries buffered, `mem_req` drops, no third ack is accepted.
  - Release: entries drain in order and fetch resumes at byte address 8.
- Redirect to `0x100` while a request to `0x8` waits 3 cycles for ack:
  - Required: `mem_addr` holds `0x8>>2` until ack, the data is discarded, the next request is `0x100>>2`.
  - Required: the first valid `insn_pc` is `0x100`.
- Redirect to `0x102`:
  - Required: one entry with `insn_fault`=01, `insn_pc`=`0x102`, `insn`=0.
  - Required: `mem_req` stays 0 until a redirect to `0x200`, which then fetches `0x200`.
- `mem_err` on the ack for `0xC`:
  - Required: a fault-10 entry at `0xC` after the earlier good entries, then no requests (HALT).
- Redirect asserted on the same edge as an ack and a pop:
  - Required: FIFO empty next cycle, the ack data is dropped, `mem_req`=1 at the redirect target the next cycle.
- Reset asserted mid-WAIT:
  - Required: outputs take their reset values immediately without waiting for a clock edge.

Source files
------------

// File: rtl/axo_fetch_if.sv
// axo_fetch_if: bundle of the fetch stage's memory port, redirect input and
// instruction output handshake.
//   master modport : the fetch stage (drives mem_req/mem_addr and the insn_* outputs)
//   slave modport  : the environment (memory, decode stage and branch unit)
// Signals:
//   mem_req/mem_addr[29:0]             read request, word address
//   mem_ack/mem_rdata[31:0]/mem_err    response for the current request
//   redirect/redirect_pc[30:0]         control transfer to byte address {redirect_pc, 1'b0}
//   insn_valid/insn_ready              output handshake
//   insn[31:0]/insn_pc[30:0]/insn_fault[1:0]  head entry of the instruction buffer
interface axo_fetch_if;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        redirect;
  logic [30:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [30:0] insn_pc;
  logic [1:0]  insn_fault;

  modport master (
    output mem_req, mem_addr, insn_valid, insn, insn_pc, insn_fault,
    input  mem_ack, mem_rdata, mem_err, redirect, redirect_pc, insn_ready
  );

  modport slave (
    input  mem_req, mem_addr, insn_valid, insn, insn_pc, insn_fault,
    output mem_ack, mem_rdata, mem_err, redirect, redirect_pc, insn_ready
  );
endinterface

// File: rtl/axo_fetch.sv
// axo_fetch: instruction fetch stage of the Axolotl32 core.
// Issues single-outstanding word reads, buffers returned words in a DEPTH-entry
// FIFO and presents {insn, insn_pc, insn_fault} to decode with valid/ready.
// A redirect flushes the FIFO; a request still in flight at that moment is
// completed and its response discarded before the new target is fetched.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : axo_fetch_if.master (memory port, redirect, instruction output)
// Parameters:
//   RESET_VEC : first fetch byte address (bits [1:0] zero)
//   DEPTH     : FIFO entries, 2..8
module axo_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input logic         clk,
  input logic         rst,
  axo_fetch_if.master bus
);

  localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  typedef enum logic [1:0] {
    RUN     = 2'd0,  // idle, or about to issue
    WAIT    = 2'd1,  // request outstanding, data wanted
    DISCARD = 2'd2,  // request outstanding, data stale
    HALT    = 2'd3   // fault queued, no more requests until a redirect
  } state_t;

  state_t      state_reg, state_next;
  logic        mem_req_reg, mem_req_next;
  logic [29:0] mem_addr_reg, mem_addr_next;
  logic [29:0] target_reg, target_next;       // refetch address held during DISCARD
  logic        halt_pend_reg, halt_pend_next; // DISCARD ends in HALT (misaligned target)

  logic [31:0] fifo_insn  [DEPTH];
  logic [30:0] fifo_pc    [DEPTH];
  logic [1:0]  fifo_fault [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [3:0]  count_reg, count_next, count_after_pop;

  logic        insn_valid, pop, ack, flush, push, misaligned;
  logic [31:0] push_insn;
  logic [30:0] push_pc;
  logic [1:0]  push_fault;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign insn_valid      = (count_reg != 4'd0);
  assign pop             = insn_valid && bus.insn_ready && !bus.redirect;
  assign ack             = mem_req_reg && bus.mem_ack;
  // redirect_pc holds byte address [31:1], so bit 0 is byte bit 1
  assign misaligned      = bus.redirect_pc[0];
  assign count_after_pop = count_reg - 4'(pop);

  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.insn_valid = insn_valid;
  assign bus.insn       = fifo_insn[rd_ptr_reg];
  assign bus.insn_pc    = fifo_pc[rd_ptr_reg];
  assign bus.insn_fault = fifo_fault[rd_ptr_reg];

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    target_next    = target_reg;
    halt_pend_next = halt_pend_reg;
    flush          = 1'b0;
    push           = 1'b0;
    push_insn      = '0;
    push_pc        = {mem_addr_reg, 1'b0};
    push_fault     = 2'b00;

    if (bus.redirect) begin
      flush = 1'b1;
      if (misaligned) begin
        push    = 1'b1;
        push_pc = bus.redirect_pc;
        push_fault = 2'b01;
      end
      if (mem_req_reg && !bus.mem_ack) begin
        // keep the request on the bus untouched until it is acked
        state_next     = DISCARD;
        target_next    = bus.redirect_pc[30:1];
        halt_pend_next = misaligned;
      end else begin
        mem_addr_next = bus.redirect_pc[30:1];
        mem_req_next  = !misaligned;
        state_next    = misaligned ? HALT : WAIT;
      end
    end else begin
      case (state_reg)
        RUN: begin
          if (count_after_pop < DEPTH_C) begin
            mem_req_next = 1'b1;
            state_next   = WAIT;
          end
        end
        WAIT: begin
          if (ack) begin
            push = 1'b1;
            if (bus.mem_err) begin
              push_fault   = 2'b10;
              mem_req_next = 1'b0;
              state_next   = HALT;
            end else begin
              push_insn     = bus.mem_rdata;
              mem_addr_next = mem_addr_reg + 30'd1;
              // the next request needs a free slot beyond the one just filled
              if (count_after_pop + 4'd1 >= DEPTH_C) begin
                mem_req_next = 1'b0;
                state_next   = RUN;
              end
            end
          end
        end
        DISCARD: begin
          if (ack) begin
            mem_addr_next = target_reg;
            mem_req_next  = !halt_pend_reg;
            state_next    = halt_pend_reg ? HALT : WAIT;
          end
        end
        HALT: begin
        end
        default: state_next = RUN;
      endcase
    end

    count_next  = flush ? 4'(push) : count_after_pop + 4'(push);
    rd_ptr_next = flush ? wr_ptr_reg : (pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg);
    wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= RESET_VEC[31:2];
      target_reg    <= RESET_VEC[31:2];
      halt_pend_reg <= 1'b0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
      target_reg    <= target_next;
      halt_pend_reg <= halt_pend_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
    end
  end

  // Storage is reset so the head outputs show defined values out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_insn[i]  <= '0;
        fifo_pc[i]    <= RESET_VEC[31:1];
        fifo_fault[i] <= 2'b00;
      end
    end else if (push) begin
      fifo_insn[wr_ptr_reg]  <= push_insn;
      fifo_pc[wr_ptr_reg]    <= push_pc;
      fifo_fault[wr_ptr_reg] <= push_fault;
    end
  end

endmodule
